ram_port_arbiter: RTL
=====================

// Module: ram_port_arbiter
// PURPOSE
//  Shares the single RAM port (MFA/MFC handshake) between three requesters:
//  trap-vector fetch, instruction fetch and data load/store. It sits between
//  controlUnit and the RAM. It serialises accesses, drives ramMFA/ramRW/
//  ramAddress/ramDataSize, returns read data, and aborts hung accesses on timeout.
// PARAMETERS
//  ADDR_W   9   RAM byte-address width
//  DATA_W   32  data width
//  TIMEOUT  16  max WAIT cycles without ramMFC before abort; 0 = never abort
// PORTS
//  Clk          in   1       clock; all state updates on negedge Clk
//  reset        in   1       asynchronous, active-low reset
//  trapReq      in   1       requester 0 (trap vector) request, highest priority
//  fetchReq     in   1       requester 1 (instruction fetch) request
//  dataReq      in   1       requester 2 (load/store) request
//  trapAddr, fetchAddr, dataAddr  in  ADDR_W  per-requester address
//  fetchSize, dataSize  in  2     per-requester ramDataSize code (trap uses 2'b11)
//  dataRW       in   1       1 = write, 0 = read (trap/fetch always read)
//  dataWdata    in   DATA_W  store data
//  ack          out  3       one-cycle completion pulse per requester {data,fetch,trap}
//  grant        out  3       one-hot owner of the in-flight access
//  err          out  1       valid with ack: access aborted by timeout
//  rdata        out  DATA_W  read data, valid with ack, held until next ack
//  busy         out  1       state != IDLE
//  ramMFA, ramRW  out  1     RAM function-active / read-write(1=write)
//  ramAddress   out  ADDR_W  RAM address
//  ramDataSize  out  2       RAM size code
//  ramDataOut   out  DATA_W  write data to RAM
//  ramDataIn    in   DATA_W  read data from RAM
//  ramMFC       in   1       RAM function-complete
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE. All outputs 0.
//   lastServed = data, so fetch wins the first fetch/data tie.
//   Reset mid-access drops it: no ack, ramMFA low immediately.
//  FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//  IDLE: if any req, select a winner:
//   - trapReq wins unconditionally.
//   - Fetch alone or data alone wins.
//   - Fetch and data both requesting: the one != lastServed wins.
//   Latch the winner's addr/size/rw/wdata, set grant, go to ISSUE.
//   Request fields are sampled only here; later changes are ignored.
//  ISSUE: ramMFA=1; ramAddress/ramDataSize/ramRW/ramDataOut driven from the latch.
//   Clear the timeout counter. Go to WAIT.
//  WAIT: ramMFA held 1, RAM outputs stable; counter increments.
//   On ramMFC=1: capture ramDataIn into rdata (reads only; writes leave rdata
//   unchanged), err=0, go to DONE.
//   Else if TIMEOUT!=0 and counter==TIMEOUT-1: err=1, go to DONE.
//  DONE: ramMFA=0. ack[winner]=1 for exactly this cycle. Update lastServed
//   (fetch/data only; trap does not change it). Clear grant.
//   Stay in DONE (ack low after first cycle) while ramMFC is still 1.
//   Go to IDLE once ramMFC=0.
//  Minimum latency: req seen in IDLE -> ack 3 cycles later (MFC on first WAIT cycle).
//  A requester holds req until ack. A req dropped early still completes and acks.
//  No preemption: trapReq arriving mid-access waits for IDLE.
//  One access in flight at a time. grant is one-hot or zero.
//  A request asserted in the same cycle DONE->IDLE is served on the next IDLE edge.
//   Back-to-back gap = 1 IDLE cycle.
// TESTING
//  1. fetchReq, fetchAddr=9'h010, RAM returns 32'h2401_0005 with MFC 1 cycle after MFA
//     -> ramAddress=9'h010, ramDataSize=2'b11, ack[1] pulse, rdata=32'h2401_0005, err=0.
//  2. fetchReq+dataReq together, held for 2 accesses
//     -> fetch served first, then data; grant order 010 then 100.
//  3. trapReq+fetchReq+dataReq together, trapAddr=9'd448
//     -> trap first (ramAddress=448), then fetch, then data.
//  4. dataReq write, dataAddr=9'h040, dataWdata=32'hDEAD_BEEF
//     -> ramRW=1, ramDataOut=32'hDEAD_BEEF; rdata unchanged; ack[2].
//  5. ramMFC never asserted, TIMEOUT=16
//     -> ramMFA high 16 WAIT cycles; ack with err=1; next request served normally.
//  6. reset low during WAIT -> all outputs 0 asynchronously; no ack.
//     Pending fetchReq after release -> served from IDLE.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : ram_port_arbiter_if
//  Description : RAM port bus carrying the MFA/MFC handshake, address, size and data.
//  Revision    : 1.0
// ============================================================================
interface ram_port_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              ramMFA;
    logic              ramRW;
    logic [ADDR_W-1:0] ramAddress;
    logic [1:0]        ramDataSize;
    logic [DATA_W-1:0] ramDataOut;
    logic [DATA_W-1:0] ramDataIn;
    logic              ramMFC;

    modport master (
        output ramMFA, ramRW, ramAddress, ramDataSize, ramDataOut,
        input  ramDataIn, ramMFC
    );

    modport slave (
        input  ramMFA, ramRW, ramAddress, ramDataSize, ramDataOut,
        output ramDataIn, ramMFC
    );
endinterface
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram_port_arbiter
//  Description : Serialises trap, fetch and load/store accesses onto one RAM
//                port with timeout abort.
//  Revision    : 1.0
// ============================================================================
module ram_port_arbiter #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  wire logic              Clk,
    input  wire logic              reset,
    input  wire logic              trapReq,
    input  wire logic              fetchReq,
    input  wire logic              dataReq,
    input  wire logic [ADDR_W-1:0] trapAddr,
    input  wire logic [ADDR_W-1:0] fetchAddr,
    input  wire logic [ADDR_W-1:0] dataAddr,
    input  wire logic [1:0]        fetchSize,
    input  wire logic [1:0]        dataSize,
    input  wire logic              dataRW,
    input  wire logic [DATA_W-1:0] dataWdata,
    output logic      [2:0]        ack,
    output logic      [2:0]        grant,
    output logic                   err,
    output logic      [DATA_W-1:0] rdata,
    output logic                   busy,
    ram_port_arbiter_if.master     ram
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        w_pick;
    logic              w_any;
    logic              w_timeout;
    logic              w_complete;

    logic [2:0]        r_owner;
    logic [2:0]        r_grant;
    logic [2:0]        r_ack;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata;
    logic              r_last_data;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_rw;
    logic [DATA_W-1:0] r_wdata;

    always_ff @(negedge Clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_any       = trapReq | fetchReq | dataReq;
        w_pick      = 3'b000;
        w_timeout   = (TIMEOUT != 0) && (r_cnt == c_cnt_last);
        w_complete  = 1'b0;

        // Fetch/data tie goes to whichever was not served last.
        if (trapReq) begin
            w_pick = 3'b001;
        end else if (fetchReq && dataReq) begin
            w_pick = r_last_data ? 3'b010 : 3'b100;
        end else if (fetchReq) begin
            w_pick = 3'b010;
        end else if (dataReq) begin
            w_pick = 3'b100;
        end

        case (r_state)
            S_IDLE:  if (w_any) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                w_complete = ram.ramMFC || w_timeout;
                if (w_complete) w_state_nxt = S_DONE;
            end
            S_DONE:  if (!ram.ramMFC) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(negedge Clk or negedge reset) begin
        if (!reset) begin
            r_owner     <= 3'b000;
            r_grant     <= 3'b000;
            r_ack       <= 3'b000;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_last_data <= 1'b1;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_size      <= 2'b00;
            r_rw        <= 1'b0;
            r_wdata     <= '0;
        end else begin
            r_ack <= w_complete ? r_owner : 3'b000;
            r_err <= w_complete && !ram.ramMFC;

            if (r_state == S_IDLE && w_any) begin
                r_owner <= w_pick;
                r_grant <= w_pick;
                if (w_pick[0]) begin
                    r_addr  <= trapAddr;
                    r_size  <= 2'b11;
                    r_rw    <= 1'b0;
                    r_wdata <= '0;
                end else if (w_pick[1]) begin
                    r_addr  <= fetchAddr;
                    r_size  <= fetchSize;
                    r_rw    <= 1'b0;
                    r_wdata <= '0;
                end else begin
                    r_addr  <= dataAddr;
                    r_size  <= dataSize;
                    r_rw    <= dataRW;
                    r_wdata <= dataWdata;
                end
            end

            if (r_state == S_ISSUE) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT && !w_complete) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_complete) begin
                r_grant <= 3'b000;
                // Trap accesses leave the fetch/data fairness history alone.
                if (r_owner[1]) begin
                    r_last_data <= 1'b0;
                end else if (r_owner[2]) begin
                    r_last_data <= 1'b1;
                end
                if (ram.ramMFC && !r_rw) begin
                    r_rdata <= ram.ramDataIn;
                end
            end
        end
    end

    assign ack             = r_ack;
    assign grant           = r_grant;
    assign err             = r_err;
    assign rdata           = r_rdata;
    assign busy            = (r_state != S_IDLE);
    assign ram.ramMFA      = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign ram.ramRW       = r_rw;
    assign ram.ramAddress  = r_addr;
    assign ram.ramDataSize = r_size;
    assign ram.ramDataOut  = r_wdata;

endmodule
`default_nettype wire
